ram_bus_master: RTL and testbench

- Bus sequencer directly upstream of the on-board byte RAM stage.
- Turns single-beat read/write requests from control logic into timed RAM bus cycles: 8-bit address, active-low bnRD/bnWR strobes, write byte on out244, read byte sampled from DBus.
- Guarantees bnRD and bnWR are never low together. Owns setup, strobe and hold timing so requesters never touch strobes directly.

---
 rtl/ram_bus_master.sv | 159 +++++++++++++++
 tb/tb_ram_bus_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// Sequencer that turns single-beat read/write requests into timed RAM bus cycles
// (setup, strobe, hold) with registered, mutually exclusive active-low strobes.
module ram_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       bclk,
    input  logic       brst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] ABus,
    output logic       bnRD,
    output logic       bnWR,
    output logic [7:0] out244,
    input  logic [7:0] DBus
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 ||
            STROBE_CYC < 2 || STROBE_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_check
            $error("ram_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC out of range");
        end
    endgenerate

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [7:0] abus_q, abus_d;
    logic [7:0] out244_q, out244_d;
    logic       bnrd_q, bnrd_d;
    logic       bnwr_q, bnwr_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;

    // Next-state, counter and datapath logic; strobes are derived from the next state
    // so they leave registers aligned with the phase boundaries.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        abus_d      = abus_q;
        out244_d    = out244_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    we_d    = req_we;
                    abus_d  = req_addr;
                    if (req_we) begin
                        out244_d = req_wdata;
                    end else begin
                        out244_d = out244_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    // Read data is sampled on the edge that closes the strobe.
                    if (!we_q) begin
                        rdata_d = DBus;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        bnrd_d  = !((state_d == ST_STROBE) && !we_d);
        bnwr_d  = !((state_d == ST_STROBE) && we_d);
    end

    // State and output registers; reset drops strobes immediately and aborts any transfer.
    always_ff @(posedge bclk or posedge brst) begin
        if (brst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            abus_q      <= 8'h00;
            out244_q    <= 8'h00;
            bnrd_q      <= 1'b1;
            bnwr_q      <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            abus_q      <= abus_d;
            out244_q    <= out244_d;
            bnrd_q      <= bnrd_d;
            bnwr_q      <= bnwr_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ABus      = abus_q;
    assign bnRD      = bnrd_q;
    assign bnWR      = bnwr_q;
    assign out244    = out244_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a default-timing instance and a 3/4/2 instance, each with a
// small RAM, checked every cycle against a cycle-offset model plus literal expectations.
module tb_ram_bus_master;

    localparam int SC [2] = '{1, 3};
    localparam int TC [2] = '{2, 4};
    localparam int HC [2] = '{1, 2};

    logic       bclk;
    logic       brst      [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic [7:0] abus      [2];
    logic       bnrd      [2];
    logic       bnwr      [2];
    logic [7:0] out244    [2];
    logic [7:0] dbus      [2];

    logic [7:0] ram [2][256];

    // Model state: when the last request was accepted and what it carried.
    int         cyc = 0;
    logic       m_active [2];
    int         m_acc    [2];
    logic       m_we     [2];
    logic [7:0] m_addr   [2];
    logic [7:0] e_abus   [2];
    logic [7:0] e_out    [2];
    logic [7:0] e_rdata  [2];
    logic [7:0] mmem     [2][256];

    int   n_tests;
    int   n_fail;
    logic prev_rsp [2];

    ram_bus_master u_dut0 (
        .bclk(bclk), .brst(brst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .ABus(abus[0]),
        .bnRD(bnrd[0]), .bnWR(bnwr[0]), .out244(out244[0]), .DBus(dbus[0])
    );

    ram_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut1 (
        .bclk(bclk), .brst(brst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .ABus(abus[1]),
        .bnRD(bnrd[1]), .bnWR(bnwr[1]), .out244(out244[1]), .DBus(dbus[1])
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // RAM: read data registered one edge after rden, write on each write-strobe edge.
    always @(posedge bclk) begin
        for (int i = 0; i < 2; i++) begin
            if (!bnrd[i]) dbus[i] <= ram[i][abus[i]];
            if (!bnwr[i]) ram[i][abus[i]] <= out244[i];
        end
    end

    function automatic logic model_ready(input int i);
        return !m_active[i] || ((cyc - m_acc[i]) >= SC[i] + TC[i] + HC[i]);
    endfunction

    always @(posedge bclk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (brst[i]) begin
                m_active[i] <= 1'b0;
                e_abus[i]   <= 8'h00;
                e_out[i]    <= 8'h00;
                e_rdata[i]  <= 8'h00;
            end else begin
                if (m_active[i] && !m_we[i] && (cyc + 1 - m_acc[i] == SC[i] + TC[i]))
                    e_rdata[i] <= mmem[i][m_addr[i]];
                if (model_ready(i) && req_valid[i]) begin
                    m_active[i] <= 1'b1;
                    m_acc[i]    <= cyc + 1;
                    m_we[i]     <= req_we[i];
                    m_addr[i]   <= req_addr[i];
                    e_abus[i]   <= req_addr[i];
                    if (req_we[i]) begin
                        e_out[i]                <= req_wdata[i];
                        mmem[i][req_addr[i]]    <= req_wdata[i];
                    end
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int   r;
            logic rs, busy, lo, done;
            r    = cyc - m_acc[i];
            rs   = brst[i];
            busy = !rs && m_active[i] && (r < SC[i] + TC[i] + HC[i]);
            done = !rs && m_active[i] && (r == SC[i] + TC[i] + HC[i]);
            lo   = !rs && m_active[i] && (r >= SC[i]) && (r < SC[i] + TC[i]);
            chk1($sformatf("ready%0d", i), req_ready[i], !busy);
            chk1($sformatf("rsp_valid%0d", i), rsp_valid[i], done);
            chk1($sformatf("bnRD%0d", i), bnrd[i], !(lo && !m_we[i]));
            chk1($sformatf("bnWR%0d", i), bnwr[i], !(lo && m_we[i]));
            chk8($sformatf("ABus%0d", i), abus[i], rs ? 8'h00 : e_abus[i]);
            chk8($sformatf("out244_%0d", i), out244[i], rs ? 8'h00 : e_out[i]);
            chk8($sformatf("rdata%0d", i), rsp_rdata[i], rs ? 8'h00 : e_rdata[i]);
            chk1($sformatf("strobe_excl%0d", i), !bnrd[i] && !bnwr[i], 1'b0);
            chk1($sformatf("rsp_twice%0d", i), prev_rsp[i] && rsp_valid[i], 1'b0);
            prev_rsp[i] = rsp_valid[i];
        end
    endtask

    // Check on the falling edge, then leave inputs settling just after the rising edge.
    task automatic tick();
        @(negedge bclk);
        compare_all();
        @(posedge bclk);
        #1;
    endtask

    // Issue one request from idle; offsets are counted in edges from the accept edge.
    task automatic txn(input int i, input logic we, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int ss, output int sl, output logic [7:0] rd);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        lat = -1; ss = -1; sl = 0; rd = 8'h00;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (k == 1) req_valid[i] = 1'b0;
            if ((we ? bnwr[i] : bnrd[i]) == 1'b0) begin
                if (ss < 0) ss = k - 1;
                sl++;
            end
            if (rsp_valid[i]) begin
                lat = k - 1;
                rd  = rsp_rdata[i];
            end
        end
        if (lat < 0) chki("txn_timeout", lat, 0);
    endtask

    initial begin
        int         lat, ss, sl, nrsp, nacc;
        int         acc_k [4];
        logic [7:0] rd, rds [2];
        logic       bb_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] bb_addr [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] bb_data [4] = '{8'h11, 8'h22, 8'h00, 8'h00};

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 2; i++) begin
            prev_rsp[i]  = 1'b0;
            brst[i]      = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
        end
        tick();
        tick();
        chk1("reset_ready", req_ready[0], 1'b1);
        chk1("reset_bnRD", bnrd[0], 1'b1);
        chk1("reset_bnWR", bnwr[1], 1'b1);
        chk8("reset_ABus", abus[1], 8'h00);
        brst[0] = 1'b0;
        brst[1] = 1'b0;
        tick();

        // Write then read back, default timing.
        txn(0, 1'b1, 8'h3C, 8'hA5, lat, ss, sl, rd);
        chki("wr_latency", lat, 4);
        chki("wr_strobe_start", ss, 1);
        chki("wr_strobe_len", sl, 2);
        chk8("wr_out244", out244[0], 8'hA5);
        chk8("wr_abus", abus[0], 8'h3C);
        txn(0, 1'b0, 8'h3C, 8'h00, lat, ss, sl, rd);
        chk8("rd_data", rd, 8'hA5);
        chki("rd_latency", lat, 4);
        chki("rd_strobe_start", ss, 1);
        chki("rd_strobe_len", sl, 2);
        chk8("rd_out244_kept", out244[0], 8'hA5);

        // Back-to-back with req_valid held high.
        nacc = 0; nrsp = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = bb_we[0];
        req_addr[0]  = bb_addr[0];
        req_wdata[0] = bb_data[0];
        for (int k = 1; k <= 60 && nrsp < 4; k++) begin
            logic rb;
            rb = req_ready[0];
            tick();
            if (rb && req_valid[0]) begin
                acc_k[nacc] = k;
                nacc++;
                if (nacc < 4) begin
                    req_we[0]    = bb_we[nacc];
                    req_addr[0]  = bb_addr[nacc];
                    req_wdata[0] = bb_data[nacc];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
            if (rsp_valid[0]) begin
                nrsp++;
                if (nrsp >= 3) rds[nrsp-3] = rsp_rdata[0];
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid[0]) nrsp++;
        end
        chki("bb_accepts", nacc, 4);
        chki("bb_gap1", acc_k[1] - acc_k[0], 5);
        chki("bb_gap2", acc_k[2] - acc_k[1], 5);
        chki("bb_gap3", acc_k[3] - acc_k[2], 5);
        chk8("bb_rd0", rds[0], 8'h11);
        chk8("bb_rd1", rds[1], 8'h22);
        chki("bb_rsp_count", nrsp, 4);

        // Inputs wiggle while busy; only the first request may take effect.
        nrsp = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h10;
        req_wdata[0] = 8'h3E;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rsp_valid[0]) nrsp++;
            if (k <= 4) begin
                chk1("busy_ready", req_ready[0], 1'b0);
                chk8("busy_abus", abus[0], 8'h10);
                req_addr[0] = 8'h20 + 8'(k);
                req_we[0]   = ~req_we[0];
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        chki("busy_rsp_count", nrsp, 1);
        chk8("busy_abus_end", abus[0], 8'h10);
        chk8("busy_out244_end", out244[0], 8'h3E);

        // Reset during the second strobe cycle of a write.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h77;
        req_wdata[0] = 8'h99;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        chk1("mid_bnWR_low", bnwr[0], 1'b0);
        brst[0] = 1'b1;
        #1;
        chk1("mid_rst_bnWR", bnwr[0], 1'b1);
        chk1("mid_rst_bnRD", bnrd[0], 1'b1);
        chk8("mid_rst_abus", abus[0], 8'h00);
        chk8("mid_rst_out244", out244[0], 8'h00);
        chk1("mid_rst_ready", req_ready[0], 1'b1);
        chk1("mid_rst_rsp", rsp_valid[0], 1'b0);
        chk8("mid_rst_rdata", rsp_rdata[0], 8'h00);
        tick();
        tick();
        brst[0] = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid[0]) nrsp++;
        end
        chki("mid_rst_no_rsp", nrsp, 0);
        txn(0, 1'b1, 8'h55, 8'hC3, lat, ss, sl, rd);
        chki("post_rst_wr_latency", lat, 4);
        txn(0, 1'b0, 8'h55, 8'h00, lat, ss, sl, rd);
        chk8("post_rst_rd_data", rd, 8'hC3);
        chki("post_rst_rd_latency", lat, 4);

        // Stretched timing instance.
        txn(1, 1'b1, 8'h42, 8'h5A, lat, ss, sl, rd);
        chki("p_wr_latency", lat, 9);
        chki("p_wr_strobe_start", ss, 3);
        chki("p_wr_strobe_len", sl, 4);
        txn(1, 1'b0, 8'h42, 8'h00, lat, ss, sl, rd);
        chk8("p_rd_data", rd, 8'h5A);
        chki("p_rd_latency", lat, 9);
        chki("p_rd_strobe_start", ss, 3);
        chki("p_rd_strobe_len", sl, 4);

        tick();
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
